alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- Buffers ALU commands (operands + opcode) in a small FIFO.
- Drives the head command onto the combinational 32-bit ALU's A/B/ALU_sel inputs.
- Registers the returned result into an output stage with valid/ready handshake and status flags.
- Sits directly upstream and downstream of the ALU: feeds it and consumes ALU_output.

Parameters:
- DEPTH, 4, command FIFO depth in entries; power of two, at least 2.
- WIDTH, 32, operand/result width; must match the ALU.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_a  input  WIDTH  operand A.
- cmd_b  input  WIDTH  operand B.
- cmd_op  input  3  ALU select code.
- alu_a  output  WIDTH  to ALU A.
- alu_b  output  WIDTH  to ALU B.
- alu_sel  output  3  to ALU_sel.
- alu_result  input  WIDTH  from ALU_output.
- res_valid  output  1  result register holds a result.
- res_ready  input  1  consumer accepts result.
- res_data  output  WIDTH  registered result.
- res_op  output  3  opcode that produced res_data.
- res_zero  output  1  res_data == 0.
- res_dbz  output  1  divide by zero (op 3'b111 with B == 0).
- count  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous, active-low.
- Reset state:
  - FIFO pointers and count = 0.
  - res_valid, res_data, res_op, res_zero, res_dbz = 0.
  - cmd_ready = 1 once reset is released.
  - Reset mid-operation discards all queued commands and any pending result; there is no partial drain.
- cmd_ready = (count != DEPTH). It depends only on registered state, with no combinational path from res_ready.
- Push: cmd_valid && cmd_ready at a rising edge writes {cmd_a, cmd_b, cmd_op} at the write pointer. Pointers wrap modulo DEPTH.
- ALU drive:
  - alu_a/alu_b/alu_sel show the head entry whenever count != 0.
  - They drive 0 when the FIFO is empty.
  - These outputs come from registered FIFO storage through the read mux only, with no logic on the inputs.
- Issue condition: issue = (count != 0) && (!res_valid || res_ready).
- On issue at a rising edge:
  - Pop the head.
  - Load res_data = alu_result and res_op = alu_sel.
  - Set res_zero = (alu_result == 0).
  - Set res_valid = 1.
  - Divide-by-zero override: if alu_sel == 3'b111 and alu_b == 0, then res_data = 32'hFFFF_FFFF, res_dbz = 1, res_zero = 0. Otherwise res_dbz = 0.
- Retire: res_valid && res_ready with no issue in the same cycle clears res_valid. res_data/flags hold their last values.
- Throughput and latency:
  - Result register plus handshake sustains one result per cycle.
  - A command pushed at edge N into an empty FIFO becomes res_valid at edge N+1; minimum latency is 1 cycle.
- Backpressure: res_valid && !res_ready freezes res_data/res_op/flags and blocks popping. The FIFO keeps filling until full.
- Simultaneous push and pop:
  - count is unchanged.
  - Allowed at any occupancy including DEPTH-1.
  - When full, push is refused because cmd_ready = 0, even if a pop occurs in the same cycle.
- Push into an empty FIFO cannot issue in the same cycle; the head is visible only after the write edge.
- Arithmetic: all wrap modulo 2^WIDTH and is performed by the ALU. This block does not recompute results apart from the dbz override.
- Ordering: results leave in strict command order.

Test Plan:
- Reset then single push of A=5, B=3, op=100 with res_ready=1 -> alu_a=5, alu_b=3, alu_sel=100 after edge 1; res_valid=1, res_data=8, res_op=100, res_zero=0 after edge 2; count returns to 0.
- Divide by zero: A=7, B=0, op=111 -> res_data=32'hFFFFFFFF, res_dbz=1, res_zero=0. A=9, B=3, op=111 -> res_data=3, res_dbz=0.
- Backpressure: res_ready=0, push 5 commands with DEPTH=4:
  - First result held in the result register, 4 commands queued, count=4, cmd_ready=0.
  - 6th push is ignored.
  - Raise res_ready -> 5 results in order, one per cycle.
- Zero flag: A=5, B=5, op=101 -> res_data=0, res_zero=1. Op 000 with A=32'hFFFFFFFF -> res_data=0, res_zero=1.
- Streaming with simultaneous push/pop at count=3, res_ready=1 for 20 cycles with random ops -> count stays 3 and every result matches the reference ALU model in order.
- Assert rst_n low mid-stream with count=2 and res_valid=1 -> immediately count=0, res_valid=0, alu_* = 0; after release the queued commands never emerge.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Command FIFO feeding a combinational ALU, with a registered result stage
// (valid/ready) that captures ALU_output plus zero / divide-by-zero flags.
module alu_issue_stage #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [WIDTH-1:0]         cmd_a,
  input  logic [WIDTH-1:0]         cmd_b,
  input  logic [2:0]               cmd_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_sel,
  input  logic [WIDTH-1:0]         alu_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [2:0]               res_op,
  output logic                     res_zero,
  output logic                     res_dbz,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [2:0] OP_DIV = 3'b111;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, issue, not_empty, dbz;

  assign not_empty = (count != '0);
  assign cmd_ready = (count != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign issue     = not_empty && (!res_valid || res_ready);

  // ALU inputs come straight off storage through the read mux; zero when empty.
  assign head    = mem[rd_ptr];
  assign alu_a   = not_empty ? head.a  : '0;
  assign alu_b   = not_empty ? head.b  : '0;
  assign alu_sel = not_empty ? head.op : '0;
  assign dbz     = (alu_sel == OP_DIV) && (alu_b == '0);

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (issue) rd_ptr <= rd_ptr + AW'(1);
      case ({push, issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
      res_zero  <= 1'b0;
      res_dbz   <= 1'b0;
    end else if (issue) begin
      res_valid <= 1'b1;
      res_op    <= alu_sel;
      if (dbz) begin
        res_data <= '1;
        res_zero <= 1'b0;
        res_dbz  <= 1'b1;
      end else begin
        res_data <= alu_result;
        res_zero <= (alu_result == '0);
        res_dbz  <= 1'b0;
      end
    end else if (res_ready) begin
      // data and flags hold their last values after retire
      res_valid <= 1'b0;
    end
  end

endmodule
